// File: rtl/cpu_defs.sv
// Shared definitions for the memory-port arbiter: FSM states, bus owner,
// default bus widths and the full-word byte-select pattern.
package cpu_defs;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int STREAK_W = 4;

  localparam logic [3:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS_IF,
    ST_BUS_D,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/arb_streak_ctr.sv
// Grant decision between fetch and data requesters. Data wins by default;
// a saturating streak counter hands the bus to a waiting fetch after
// MAX_D_STREAK consecutive data grants.
module arb_streak_ctr
  import cpu_defs::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic grant_if_o,
  output logic grant_d_o
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // Grant decision and next streak value; only meaningful while arbitrating.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    streak_d   = streak_q;
    grant_d_o  = arb_en_i & d_req_i & (~if_req_i | (streak_q < STREAK_MAX));
    grant_if_o = arb_en_i & if_req_i & ~grant_d_o;
    if (arb_en_i) begin
      if (!if_req_i || grant_if_o) begin
        streak_d = '0;
      end else if (grant_d_o && (streak_q != '1)) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  // Streak register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the fetch and data requesters.
// Serialises accesses, registers returned data, pulses per-requester acks,
// raises stall requests, frees the bus on slave timeout and discards flushed
// fetches.
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  input  logic          flush_i,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [3:0]    d_sel_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ack_o,
  output logic          stallreq_if_o,
  output logic          stallreq_mem_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [3:0]    bus_sel_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic [DW-1:0] bus_rdata_i,
  input  logic          bus_ack_i,
  output logic          bus_err_o
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [3:0]    bus_sel_q, bus_sel_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          bus_err_q, bus_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          discard_q, discard_d;

  logic grant_if, grant_d;
  logic tmo_hit;
  logic discard_now;

  arb_streak_ctr #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk       (clk),
    .rst       (rst),
    .arb_en_i  (state_q == ST_IDLE),
    .if_req_i  (if_req_i),
    .d_req_i   (d_req_i),
    .grant_if_o(grant_if),
    .grant_d_o (grant_d)
  );

  assign tmo_hit     = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
  // A flush arriving in the completing cycle of a fetch still kills its ack.
  assign discard_now = discard_q | ((state_q == ST_BUS_IF) & flush_i);

  // Next-state and datapath logic for the bus FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    tmo_d       = tmo_q;
    discard_d   = discard_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d     = ST_BUS_D;
          owner_d     = OWN_D;
          bus_req_d   = 1'b1;
          bus_we_d    = d_we_i;
          bus_sel_d   = d_sel_i;
          bus_addr_d  = d_addr_i;
          bus_wdata_d = d_wdata_i;
          tmo_d       = '0;
        end else if (grant_if) begin
          state_d     = ST_BUS_IF;
          owner_d     = OWN_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = SEL_WORD;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          tmo_d       = '0;
          discard_d   = flush_i;
        end
      end

      ST_BUS_IF, ST_BUS_D: begin
        discard_d = discard_now;
        if (bus_ack_i) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus_we_q ? '0 : bus_rdata_i;
          end else begin
            if_ack_d   = ~discard_now;
            if_rdata_d = bus_rdata_i;
          end
        end else if (tmo_hit) begin
          // Slave never answered: complete with zero data and flag the error.
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
            bus_err_d = 1'b1;
          end else begin
            if_ack_d   = ~discard_now;
            if_rdata_d = '0;
            bus_err_d  = ~discard_now;
          end
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_RESP: begin
        state_d   = ST_IDLE;
        discard_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight bus cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      tmo_q       <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
      tmo_q       <= tmo_d;
      discard_q   <= discard_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign bus_err_o   = bus_err_q;

  assign stallreq_if_o  = if_req_i & ~if_ack_q;
  assign stallreq_mem_o = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, contention,
// fetch starvation guard, timeout, flush and mid-cycle reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        flush_i;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int n_vec  = 0;
  int n_miss = 0;

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_rdata_o    (if_rdata_o),
    .if_ack_o      (if_ack_o),
    .flush_i       (flush_i),
    .d_req_i       (d_req_i),
    .d_we_i        (d_we_i),
    .d_sel_i       (d_sel_i),
    .d_addr_i      (d_addr_i),
    .d_wdata_i     (d_wdata_i),
    .d_rdata_o     (d_rdata_o),
    .d_ack_o       (d_ack_o),
    .stallreq_if_o (stallreq_if_o),
    .stallreq_mem_o(stallreq_mem_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_sel_o     (bus_sel_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rdata_i   (bus_rdata_i),
    .bus_ack_i     (bus_ack_i),
    .bus_err_o     (bus_err_o)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first bus cycle: holds off the ack for 'waits' cycles, then
  // acks with rdata. Returns in the response cycle with the bus_req cycle count.
  task automatic bus_cycle(input int waits, input logic [31:0] rdata, output int req_cycles);
    req_cycles = 0;
    for (int i = 0; i < waits; i++) begin
      if (bus_req_o) req_cycles++;
      tick();
    end
    if (bus_req_o) req_cycles++;
    bus_ack_i   = 1'b1;
    bus_rdata_i = rdata;
    tick();
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req_i = 0; if_addr_i = '0; flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_sel_i = '0; d_addr_i = '0; d_wdata_i = '0;
    bus_rdata_i = '0; bus_ack_i = 0;
    tick(); tick();
    n_vec++; if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== '0) begin n_miss++; $display("FAIL reset_bus: got %b/%b/%h/%h/%h want all 0", bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o); end
    n_vec++; if ({if_ack_o, d_ack_o, bus_err_o, if_rdata_o, d_rdata_o} !== '0) begin n_miss++; $display("FAIL reset_resp: got %b/%b/%b/%h/%h want all 0", if_ack_o, d_ack_o, bus_err_o, if_rdata_o, d_rdata_o); end
    #2 rst = 1'b1;
    tick();
    // A stray slave ack in IDLE must not produce anything.
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    n_vec++; if ({bus_req_o, if_ack_o, d_ack_o} !== 3'b000) begin n_miss++; $display("FAIL stray_ack: got req/ifack/dack %b%b%b want 000", bus_req_o, if_ack_o, d_ack_o); end
    tick();
    n_vec++; if ({if_ack_o, d_ack_o, bus_err_o} !== 3'b000) begin n_miss++; $display("FAIL stray_ack_late: got %b%b%b want 000", if_ack_o, d_ack_o, bus_err_o); end
  endtask

  task automatic test_single_fetch();
    int rc;
    if_req_i = 1; if_addr_i = 32'h100;
    #1;
    n_vec++; if (stallreq_if_o !== 1'b1) begin n_miss++; $display("FAIL fetch_stall_on: got %b want 1", stallreq_if_o); end
    tick();
    n_vec++; if ({bus_addr_o, bus_we_o, bus_sel_o} !== {32'h100, 1'b0, 4'b1111}) begin n_miss++; $display("FAIL fetch_fields: got %h/%b/%b want 00000100/0/1111", bus_addr_o, bus_we_o, bus_sel_o); end
    bus_cycle(2, 32'h3C01_0001, rc);
    n_vec++; if (rc !== 3) begin n_miss++; $display("FAIL fetch_req_cycles: got %0d want 3", rc); end
    n_vec++; if ({bus_req_o, if_ack_o, d_ack_o} !== 3'b010) begin n_miss++; $display("FAIL fetch_ack: got req/ifack/dack %b%b%b want 010", bus_req_o, if_ack_o, d_ack_o); end
    n_vec++; if (if_rdata_o !== 32'h3C01_0001) begin n_miss++; $display("FAIL fetch_rdata: got %h want 3c010001", if_rdata_o); end
    n_vec++; if (stallreq_if_o !== 1'b0) begin n_miss++; $display("FAIL fetch_stall_off: got %b want 0", stallreq_if_o); end
    if_req_i = 0;
    tick();
    n_vec++; if (if_ack_o !== 1'b0) begin n_miss++; $display("FAIL fetch_ack_width: got %b want 0", if_ack_o); end
  endtask

  task automatic test_contention();
    int rc;
    if_req_i = 1; if_addr_i = 32'h300;
    d_req_i = 1; d_we_i = 1; d_sel_i = 4'b0011; d_addr_i = 32'h200; d_wdata_i = 32'hDEAD_BEEF;
    #1;
    n_vec++; if ({stallreq_if_o, stallreq_mem_o} !== 2'b11) begin n_miss++; $display("FAIL cont_stalls: got %b%b want 11", stallreq_if_o, stallreq_mem_o); end
    tick();
    n_vec++; if ({bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o} !== {32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF}) begin n_miss++; $display("FAIL cont_d_fields: got %h/%b/%b/%h want 00000200/1/0011/deadbeef", bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o); end
    bus_cycle(1, 32'h1234_5678, rc);
    n_vec++; if ({d_ack_o, if_ack_o} !== 2'b10) begin n_miss++; $display("FAIL cont_d_ack: got dack/ifack %b%b want 10", d_ack_o, if_ack_o); end
    n_vec++; if (d_rdata_o !== 32'h0) begin n_miss++; $display("FAIL cont_write_rdata: got %h want 00000000", d_rdata_o); end
    n_vec++; if ({stallreq_if_o, stallreq_mem_o} !== 2'b10) begin n_miss++; $display("FAIL cont_stalls_resp: got %b%b want 10", stallreq_if_o, stallreq_mem_o); end
    d_req_i = 0; d_we_i = 0;
    tick();
    tick();
    n_vec++; if ({bus_req_o, bus_addr_o, bus_we_o, bus_sel_o} !== {1'b1, 32'h300, 1'b0, 4'b1111}) begin n_miss++; $display("FAIL cont_if_fields: got %b/%h/%b/%b want 1/00000300/0/1111", bus_req_o, bus_addr_o, bus_we_o, bus_sel_o); end
    bus_cycle(0, 32'hCAFE_0001, rc);
    n_vec++; if ({if_ack_o, if_rdata_o} !== {1'b1, 32'hCAFE_0001}) begin n_miss++; $display("FAIL cont_if_ack: got %b/%h want 1/cafe0001", if_ack_o, if_rdata_o); end
    if_req_i = 0;
    tick();
  endtask

  task automatic test_starvation();
    int rc;
    logic [5:0] exp_if = 6'b010000;
    logic [31:0] exp_addr;
    if_req_i = 1; if_addr_i = 32'h1000;
    d_req_i = 1; d_we_i = 0; d_sel_i = 4'b1111; d_addr_i = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      exp_addr = exp_if[k] ? 32'h1000 : 32'h2000;
      tick();
      n_vec++; if (bus_addr_o !== exp_addr) begin n_miss++; $display("FAIL starve_grant%0d: got addr %h want %h", k, bus_addr_o, exp_addr); end
      bus_cycle(0, 32'hD000_0000 + 32'(k), rc);
      n_vec++; if ({if_ack_o, d_ack_o} !== {exp_if[k], ~exp_if[k]}) begin n_miss++; $display("FAIL starve_ack%0d: got ifack/dack %b%b want %b%b", k, if_ack_o, d_ack_o, exp_if[k], ~exp_if[k]); end
      if (k == 5) begin
        if_req_i = 0; d_req_i = 0;
      end
      tick();
    end
    n_vec++; if (d_rdata_o !== 32'hD000_0005) begin n_miss++; $display("FAIL starve_rdata: got %h want d0000005", d_rdata_o); end
  endtask

  task automatic test_timeout();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_vec++; if ({bus_req_o, d_ack_o} !== 2'b10) begin n_miss++; $display("FAIL tmo_wait%0d: got req/dack %b%b want 10", i, bus_req_o, d_ack_o); end
      tick();
    end
    n_vec++; if ({bus_req_o, d_ack_o, bus_err_o} !== 3'b011) begin n_miss++; $display("FAIL tmo_fire: got req/dack/err %b%b%b want 011", bus_req_o, d_ack_o, bus_err_o); end
    n_vec++; if (d_rdata_o !== 32'h0) begin n_miss++; $display("FAIL tmo_rdata: got %h want 00000000", d_rdata_o); end
    d_req_i = 0;
    tick();
    n_vec++; if ({d_ack_o, bus_err_o} !== 2'b00) begin n_miss++; $display("FAIL tmo_pulse: got dack/err %b%b want 00", d_ack_o, bus_err_o); end
    // Ack arriving in the cycle that would otherwise time out.
    d_req_i = 1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    n_vec++; if (bus_req_o !== 1'b1) begin n_miss++; $display("FAIL tmo_race_req: got %b want 1", bus_req_o); end
    bus_ack_i = 1; bus_rdata_i = 32'h55AA_55AA;
    tick();
    bus_ack_i = 0; bus_rdata_i = '0;
    n_vec++; if ({d_ack_o, bus_err_o, d_rdata_o} !== {1'b1, 1'b0, 32'h55AA_55AA}) begin n_miss++; $display("FAIL tmo_race: got dack/err/rdata %b/%b/%h want 1/0/55aa55aa", d_ack_o, bus_err_o, d_rdata_o); end
    d_req_i = 0;
    tick();
  endtask

  task automatic test_flush();
    int rc;
    if_req_i = 1; if_addr_i = 32'h500;
    tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    n_vec++; if (bus_req_o !== 1'b1) begin n_miss++; $display("FAIL flush_bus_kept: got %b want 1", bus_req_o); end
    bus_ack_i = 1; bus_rdata_i = 32'h1111_1111;
    tick();
    bus_ack_i = 0; bus_rdata_i = '0;
    n_vec++; if ({bus_req_o, if_ack_o, bus_err_o} !== 3'b000) begin n_miss++; $display("FAIL flush_no_ack: got req/ifack/err %b%b%b want 000", bus_req_o, if_ack_o, bus_err_o); end
    if_addr_i = 32'h504;
    tick();
    tick();
    n_vec++; if (bus_addr_o !== 32'h504) begin n_miss++; $display("FAIL flush_refetch_addr: got %h want 00000504", bus_addr_o); end
    bus_cycle(0, 32'h2222_2222, rc);
    n_vec++; if ({if_ack_o, if_rdata_o} !== {1'b1, 32'h2222_2222}) begin n_miss++; $display("FAIL flush_refetch_ack: got %b/%h want 1/22222222", if_ack_o, if_rdata_o); end
    if_req_i = 0;
    tick();
  endtask

  task automatic test_reset_mid_cycle();
    d_req_i = 1; d_we_i = 1; d_sel_i = 4'b1111; d_addr_i = 32'h600; d_wdata_i = 32'hA5A5_A5A5;
    tick();
    tick();
    n_vec++; if (bus_req_o !== 1'b1) begin n_miss++; $display("FAIL rmid_busy: got %b want 1", bus_req_o); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== '0) begin n_miss++; $display("FAIL rmid_bus_clear: got %b/%b/%b/%h/%h want all 0", bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o); end
    n_vec++; if ({if_ack_o, d_ack_o, bus_err_o, if_rdata_o, d_rdata_o} !== '0) begin n_miss++; $display("FAIL rmid_resp_clear: got %b/%b/%b/%h/%h want all 0", if_ack_o, d_ack_o, bus_err_o, if_rdata_o, d_rdata_o); end
    d_req_i = 0; d_we_i = 0;
    tick();
    #2 rst = 1'b1;
    tick();
    d_req_i = 1; d_addr_i = 32'h700;
    tick();
    n_vec++; if ({bus_req_o, bus_addr_o, d_ack_o} !== {1'b1, 32'h700, 1'b0}) begin n_miss++; $display("FAIL rmid_fresh_grant: got %b/%h/%b want 1/00000700/0", bus_req_o, bus_addr_o, d_ack_o); end
    bus_ack_i = 1; bus_rdata_i = 32'h0000_0777;
    tick();
    bus_ack_i = 0; bus_rdata_i = '0;
    n_vec++; if ({d_ack_o, d_rdata_o} !== {1'b1, 32'h0000_0777}) begin n_miss++; $display("FAIL rmid_fresh_ack: got %b/%h want 1/00000777", d_ack_o, d_rdata_o); end
    d_req_i = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_timeout();
    test_flush();
    test_reset_mid_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
